// File: rtl/axi_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_responder_pkg
// Description : Shared AXI burst/response encodings and the write/read FSM
//               state types used by the SRAM responder and its address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_sram_responder_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_sram_burst_addr.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_burst_addr
// Description : Combinational next-beat address and request error check for
//               one AXI burst. WRAP support is compiled in only when the macro
//               AXI_SRAM_RESPONDER_WRAP_EN is defined; otherwise WRAP errors.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_burst_addr
  import axi_sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_WORDS  = 1024
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  err
);

  localparam int OFF = $clog2(DATA_WIDTH/8);
  localparam logic [ADDR_WIDTH-1:0] ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   SPAN = (ADDR_WIDTH+1)'(MEM_WORDS) << OFF;

  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] len_span;
  logic [ADDR_WIDTH:0]   last_addr;
  logic                  range_err;
  logic                  size_err;
  logic                  burst_err;

  assign bytes     = ONE << size;
  assign aligned   = addr & ~(bytes - ONE);
  assign incr_addr = aligned + bytes;
  assign len_span  = {{(ADDR_WIDTH-8){1'b0}}, len} << size;

`ifdef AXI_SRAM_RESPONDER_WRAP_EN
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] wrap_addr;
  // Window is (len+1)<<size bytes, always a power of two for legal lengths
  assign wrap_mask = (({{(ADDR_WIDTH-8){1'b0}}, len} + ONE) << size) - ONE;
  assign wrap_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
  assign burst_err = (burst == 2'b11) ||
                     ((burst == BURST_WRAP) &&
                      !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
`else
  assign burst_err = (burst == 2'b11) || (burst == BURST_WRAP);
`endif

  // Last beat address: a wrap window is aligned and never larger than the
  // array, so its start address alone decides whether it is in range.
  always_comb begin
    last_addr = {1'b0, addr};
    if (burst == BURST_INCR) begin
      last_addr = {1'b0, aligned} + {1'b0, len_span};
    end
  end

  assign range_err = ({1'b0, addr} >= SPAN) || (last_addr >= SPAN);
  assign size_err  = size > 3'(OFF);
  assign err       = burst_err || size_err || range_err;

  // Address of the following beat for the current burst type
  always_comb begin
    next_addr = incr_addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
`ifdef AXI_SRAM_RESPONDER_WRAP_EN
      BURST_WRAP:  next_addr = wrap_addr;
`endif
      default:     next_addr = incr_addr;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_responder
// Description : AXI4 subordinate backed by a flat word array. One write burst
//               and one read burst in flight, independent paths, ID echo and
//               SLVERR on illegal requests. Optional WRAP support is enabled
//               by defining AXI_SRAM_RESPONDER_WRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_responder
  import axi_sram_responder_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int MEM_WORDS      = 1024
) (
  input  logic                        aclk,
  input  logic                        rstn,
  input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                  s_axi_awlen,
  input  logic [2:0]                  s_axi_awsize,
  input  logic [1:0]                  s_axi_awburst,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wlast,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                  s_axi_arlen,
  input  logic [2:0]                  s_axi_arsize,
  input  logic [1:0]                  s_axi_arburst,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rlast,
  output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready
);

  localparam int OFF    = $clog2(AXI_DATA_WIDTH/8);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int STRB_W = AXI_DATA_WIDTH/8;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Write path state
  wr_state_t                 w_state;
  logic [AXI_ID_WIDTH-1:0]   w_id;
  logic [AXI_ADDR_WIDTH-1:0] w_addr;
  logic [7:0]                w_len;
  logic [7:0]                w_cnt;
  logic [2:0]                w_size;
  logic [1:0]                w_burst;
  logic                      w_err;
  logic                      w_idle;
  logic                      w_beat;
  logic                      w_calc_err;
  logic [AXI_ADDR_WIDTH-1:0] w_next;

  // Read path state
  rd_state_t                 r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                r_len;
  logic [7:0]                r_beat;
  logic [2:0]                r_size;
  logic [1:0]                r_burst;
  logic                      r_err;
  logic                      r_idle;
  logic                      r_calc_err;
  logic [AXI_ADDR_WIDTH-1:0] r_next;
  logic [IDX_W-1:0]          r_idx;

  // While idle each helper evaluates the incoming request for the error
  // check; during a burst it steps the latched address.
  assign w_idle = (w_state == W_IDLE);
  assign r_idle = (r_state == R_IDLE);
  assign w_beat = (w_state == W_DATA) && s_axi_wvalid;
  assign r_idx  = r_idle ? s_axi_araddr[IDX_W+OFF-1:OFF] : r_next[IDX_W+OFF-1:OFF];

  axi_sram_burst_addr #(
    .ADDR_WIDTH (AXI_ADDR_WIDTH),
    .DATA_WIDTH (AXI_DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_wr_addr (
    .addr      (w_idle ? s_axi_awaddr  : w_addr),
    .len       (w_idle ? s_axi_awlen   : w_len),
    .size      (w_idle ? s_axi_awsize  : w_size),
    .burst     (w_idle ? s_axi_awburst : w_burst),
    .next_addr (w_next),
    .err       (w_calc_err)
  );

  axi_sram_burst_addr #(
    .ADDR_WIDTH (AXI_ADDR_WIDTH),
    .DATA_WIDTH (AXI_DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_rd_addr (
    .addr      (r_idle ? s_axi_araddr  : r_addr),
    .len       (r_idle ? s_axi_arlen   : r_len),
    .size      (r_idle ? s_axi_arsize  : r_size),
    .burst     (r_idle ? s_axi_arburst : r_burst),
    .next_addr (r_next),
    .err       (r_calc_err)
  );

  // Byte-lane array write for each accepted W beat of a legal burst
  always_ff @(posedge aclk) begin
    if (w_beat && !w_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) begin
          mem[w_addr[IDX_W+OFF-1:OFF]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Write FSM: accept AW, consume W beats, return B
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= RESP_OKAY;
      w_id          <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_size        <= '0;
      w_burst       <= '0;
      w_err         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_id          <= s_axi_awid;
            w_addr        <= s_axi_awaddr;
            w_len         <= s_axi_awlen;
            w_size        <= s_axi_awsize;
            w_burst       <= s_axi_awburst;
            w_err         <= w_calc_err;
            w_cnt         <= '0;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_axi_wvalid) begin
            w_addr <= w_next;
            w_cnt  <= w_cnt + 8'd1;
            // A beat count of len+1 closes the burst even without wlast
            if (s_axi_wlast || (w_cnt == w_len)) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= w_id;
              s_axi_bresp  <= w_err ? RESP_SLVERR : RESP_OKAY;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: accept AR, stream len+1 R beats with prefetched data
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rdata   <= '0;
      s_axi_rlast   <= 1'b0;
      r_addr        <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rid     <= s_axi_arid;
            s_axi_rresp   <= r_calc_err ? RESP_SLVERR : RESP_OKAY;
            s_axi_rdata   <= r_calc_err ? '0 : mem[r_idx];
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            r_addr        <= s_axi_araddr;
            r_len         <= s_axi_arlen;
            r_size        <= s_axi_arsize;
            r_burst       <= s_axi_arburst;
            r_err         <= r_calc_err;
            r_beat        <= '0;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_beat      <= r_beat + 8'd1;
              r_addr      <= r_next;
              s_axi_rdata <= r_err ? '0 : mem[r_idx];
              s_axi_rlast <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_sram_responder
// Description : Self-checking bench for axi_sram_responder. Expected R beats
//               are queued from a bench-side memory model when the AR is
//               issued and compared as the DUT returns them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_sram_responder;

  localparam logic [1:0] B_FIXED = 2'b00;
  localparam logic [1:0] B_INCR  = 2'b01;
  localparam logic [1:0] B_WRAP  = 2'b10;
  localparam logic [1:0] OKAY    = 2'b00;
  localparam logic [1:0] SLVERR  = 2'b10;

  logic        aclk;
  logic        rstn;
  logic [3:0]  awid;   logic [63:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
  logic [1:0]  awburst; logic awvalid; logic awready;
  logic [63:0] wdata;  logic [7:0] wstrb;  logic wlast; logic wvalid; logic wready;
  logic [3:0]  bid;    logic [1:0] bresp;  logic bvalid; logic bready;
  logic [3:0]  arid;   logic [63:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
  logic [1:0]  arburst; logic arvalid; logic arready;
  logic [63:0] rdata;  logic [1:0] rresp;  logic rlast; logic [3:0] rid;
  logic rvalid; logic rready;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] model [1024];
  logic [63:0] wq_data[$];
  logic [7:0]  wq_strb[$];
  logic [63:0] exp_data[$];
  logic        exp_last[$];
  logic [63:0] got_data[$];
  logic [1:0]  got_resp[$];
  logic        got_last[$];
  logic [3:0]  got_id[$];

  axi_sram_responder dut (
    .aclk(aclk), .rstn(rstn),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast), .s_axi_rid(rid),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------------------------------------------------------- drivers
  task automatic write_burst(input logic [3:0] id, input logic [63:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, output logic [3:0] g_bid,
                             output logic [1:0] g_bresp, output bit timeout);
    bit hs;
    timeout = 0; g_bid = '0; g_bresp = '0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    hs = 0;
    for (int n = 0; n < 50 && !hs; n++) begin hs = awready; @(posedge aclk); #1; end
    awvalid = 1'b0;
    if (!hs) timeout = 1;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = wq_data[b]; wstrb = wq_strb[b]; wlast = (b == int'(len)); wvalid = 1'b1;
      hs = 0;
      for (int n = 0; n < 50 && !hs; n++) begin hs = wready; @(posedge aclk); #1; end
      if (!hs) timeout = 1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1; hs = 0;
    for (int n = 0; n < 50 && !hs; n++) begin
      if (bvalid) begin hs = 1; g_bid = bid; g_bresp = bresp; end
      @(posedge aclk); #1;
    end
    bready = 1'b0;
    if (!hs) timeout = 1;
    wq_data.delete(); wq_strb.delete();
  endtask

  task automatic issue_ar(input logic [3:0] id, input logic [63:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, output bit timeout);
    bit hs;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    hs = 0;
    for (int n = 0; n < 50 && !hs; n++) begin hs = arready; @(posedge aclk); #1; end
    arvalid = 1'b0;
    timeout = !hs;
  endtask

  // Collects R beats into the got_* queues; lat is set when rvalid is
  // already high in the cycle right after the AR handshake.
  task automatic read_burst(input logic [3:0] id, input logic [63:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input bit toggle,
                            output bit timeout, output bit lat);
    bit done;
    int beats;
    issue_ar(id, addr, len, size, burst, timeout);
    lat = rvalid;
    done = 0; beats = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      rready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (rvalid && rready) begin
        got_data.push_back(rdata); got_resp.push_back(rresp);
        got_last.push_back(rlast); got_id.push_back(rid);
        beats++;
        if (rlast || beats == int'(len) + 1) done = 1;
      end
      @(posedge aclk); #1;
    end
    rready = 1'b0;
    if (!done) timeout = 1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rstn = 1'b0;
    awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
    repeat (2) @(posedge aclk);
    #1;
    vectors++;
    if ({awready, arready, wready, bvalid, rvalid, rlast, bid, rid, bresp, rresp, rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: aw=%b ar=%b w=%b bv=%b rv=%b rl=%b bid=%h rid=%h br=%h rr=%h rd=%h, want all 0",
               awready, arready, wready, bvalid, rvalid, rlast, bid, rid, bresp, rresp, rdata);
    end
    @(negedge aclk); rstn = 1'b1;
    @(posedge aclk); #1;
    vectors++;
    if ({awready, arready} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_ready_rise: awready=%b arready=%b, want 1 1", awready, arready);
    end
  endtask

  task automatic test_incr();
    logic [3:0] gb; logic [1:0] gr; bit to, lat;
    for (int i = 0; i < 4; i++) begin
      wq_data.push_back(64'(i + 1)); wq_strb.push_back(8'hFF); model[8 + i] = 64'(i + 1);
    end
    write_burst(4'd3, 64'h40, 8'd3, 3'd3, B_INCR, gb, gr, to);
    vectors++;
    if (to || gb !== 4'd3 || gr !== OKAY) begin
      miscompares++;
      $display("FAIL incr_bresp: timeout=%0b bid=%0d bresp=%0d, want bid=3 bresp=0", to, gb, gr);
    end
    for (int i = 0; i < 4; i++) begin exp_data.push_back(model[8 + i]); exp_last.push_back(i == 3); end
    read_burst(4'd5, 64'h40, 8'd3, 3'd3, B_INCR, 1'b0, to, lat);
    vectors++;
    if (to || !lat) begin
      miscompares++;
      $display("FAIL incr_rvalid_latency: timeout=%0b rvalid_next_cycle=%0b, want 0 1", to, lat);
    end
    while (exp_data.size() > 0) begin
      logic [63:0] ed; logic el;
      ed = exp_data.pop_front(); el = exp_last.pop_front();
      vectors++;
      if (got_data.size() == 0) begin
        miscompares++; $display("FAIL incr_rbeat: missing beat, want data=%h", ed);
      end else begin
        logic [63:0] d; logic [1:0] r; logic l; logic [3:0] id;
        d = got_data.pop_front(); r = got_resp.pop_front(); l = got_last.pop_front(); id = got_id.pop_front();
        if (d !== ed || r !== OKAY || l !== el || id !== 4'd5) begin
          miscompares++;
          $display("FAIL incr_rbeat: data=%h resp=%0d last=%0b id=%0d, want %h 0 %0b 5", d, r, l, id, ed, el);
        end
      end
    end
  endtask

  task automatic test_narrow();
    logic [3:0] gb; logic [1:0] gr; bit to, lat;
    wq_data.push_back(64'h1122_3344_5566_7788); wq_strb.push_back(8'hFF);
    model[32] = 64'h1122_3344_5566_7788;
    write_burst(4'd1, 64'h100, 8'd0, 3'd3, B_INCR, gb, gr, to);
    wq_data.push_back(64'h0000_0000_0000_AA00); wq_strb.push_back(8'h02);
    model[32][15:8] = 8'hAA;
    write_burst(4'd2, 64'h101, 8'd0, 3'd0, B_INCR, gb, gr, to);
    vectors++;
    if (to || gb !== 4'd2 || gr !== OKAY) begin
      miscompares++;
      $display("FAIL narrow_bresp: timeout=%0b bid=%0d bresp=%0d, want bid=2 bresp=0", to, gb, gr);
    end
    exp_data.push_back(model[32]);
    read_burst(4'd6, 64'h100, 8'd0, 3'd3, B_INCR, 1'b0, to, lat);
    vectors++;
    if (to || got_data.size() != 1) begin
      miscompares++; $display("FAIL narrow_read: timeout=%0b beats=%0d, want 0 1", to, got_data.size());
      got_data.delete(); got_resp.delete(); got_last.delete(); got_id.delete(); exp_data.delete();
    end else begin
      logic [63:0] d, ed; logic [1:0] r; logic l; logic [3:0] id;
      d = got_data.pop_front(); r = got_resp.pop_front(); l = got_last.pop_front(); id = got_id.pop_front();
      ed = exp_data.pop_front();
      if (d !== ed || r !== OKAY || l !== 1'b1) begin
        miscompares++;
        $display("FAIL narrow_read: data=%h resp=%0d last=%0b, want %h 0 1", d, r, l, ed);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] gb; logic [1:0] gr; bit to, lat;
    logic [1:0] eresp;
    for (int i = 0; i < 4; i++) begin
      wq_data.push_back(64'hA0 + 64'(i)); wq_strb.push_back(8'hFF); model[i] = 64'hA0 + 64'(i);
    end
    write_burst(4'd4, 64'h0, 8'd3, 3'd3, B_INCR, gb, gr, to);
`ifdef AXI_SRAM_RESPONDER_WRAP_EN
    eresp = OKAY;
    exp_data.push_back(model[3]); exp_data.push_back(model[0]);
    exp_data.push_back(model[1]); exp_data.push_back(model[2]);
`else
    eresp = SLVERR;
    for (int i = 0; i < 4; i++) exp_data.push_back(64'h0);
`endif
    for (int i = 0; i < 4; i++) exp_last.push_back(i == 3);
    read_burst(4'd7, 64'h18, 8'd3, 3'd3, B_WRAP, 1'b0, to, lat);
    vectors++;
    if (to) begin miscompares++; $display("FAIL wrap_timeout: timeout=1, want 0"); end
    while (exp_data.size() > 0) begin
      logic [63:0] ed; logic el;
      ed = exp_data.pop_front(); el = exp_last.pop_front();
      vectors++;
      if (got_data.size() == 0) begin
        miscompares++; $display("FAIL wrap_rbeat: missing beat, want data=%h", ed);
      end else begin
        logic [63:0] d; logic [1:0] r; logic l; logic [3:0] id;
        d = got_data.pop_front(); r = got_resp.pop_front(); l = got_last.pop_front(); id = got_id.pop_front();
        if (d !== ed || r !== eresp || l !== el || id !== 4'd7) begin
          miscompares++;
          $display("FAIL wrap_rbeat: data=%h resp=%0d last=%0b id=%0d, want %h %0d %0b 7", d, r, l, id, ed, eresp, el);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [3:0] gb; logic [1:0] gr; bit to, lat;
    for (int i = 0; i < 2; i++) begin wq_data.push_back(64'hDEAD_BEEF_0000_0000 + 64'(i)); wq_strb.push_back(8'hFF); end
    write_burst(4'd9, 64'h2000, 8'd1, 3'd3, B_INCR, gb, gr, to);
    vectors++;
    if (to || gb !== 4'd9 || gr !== SLVERR) begin
      miscompares++;
      $display("FAIL oor_bresp: timeout=%0b bid=%0d bresp=%0d, want bid=9 bresp=2", to, gb, gr);
    end
    // Word 0 shares the index bits of 0x2000 and must be untouched
    exp_data.push_back(model[0]); exp_data.push_back(model[1]);
    exp_data.push_back(64'h0); exp_data.push_back(64'h0);
    read_burst(4'd1, 64'h0, 8'd1, 3'd3, B_INCR, 1'b0, to, lat);
    read_burst(4'd2, 64'h2000, 8'd1, 3'd3, B_INCR, 1'b0, to, lat);
    for (int i = 0; i < 4; i++) begin
      logic [63:0] ed;
      ed = exp_data.pop_front();
      vectors++;
      if (got_data.size() == 0) begin
        miscompares++; $display("FAIL oor_rbeat%0d: missing beat, want data=%h", i, ed);
      end else begin
        logic [63:0] d; logic [1:0] r; logic l; logic [3:0] id;
        d = got_data.pop_front(); r = got_resp.pop_front(); l = got_last.pop_front(); id = got_id.pop_front();
        if (d !== ed || r !== ((i < 2) ? OKAY : SLVERR) || l !== (i % 2 == 1)) begin
          miscompares++;
          $display("FAIL oor_rbeat%0d: data=%h resp=%0d last=%0b, want %h %0d %0b",
                   i, d, r, l, ed, (i < 2) ? OKAY : SLVERR, (i % 2 == 1));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] gb; logic [1:0] gr; bit to, tor, tow, lat;
    for (int i = 0; i < 16; i++) begin
      wq_data.push_back({32'h0400_0000, 32'(i * 7 + 3)}); wq_strb.push_back(8'hFF);
      model[128 + i] = {32'h0400_0000, 32'(i * 7 + 3)};
    end
    write_burst(4'd0, 64'h400, 8'd15, 3'd3, B_INCR, gb, gr, to);
    for (int i = 0; i < 16; i++) exp_data.push_back(model[128 + i]);
    for (int i = 0; i < 16; i++) begin
      wq_data.push_back({32'h1000_0000, 32'(i * 13 + 1)}); wq_strb.push_back(8'hFF);
      model[512 + i] = {32'h1000_0000, 32'(i * 13 + 1)};
    end
    fork
      read_burst(4'd11, 64'h400, 8'd15, 3'd3, B_INCR, 1'b1, tor, lat);
      write_burst(4'd12, 64'h1000, 8'd15, 3'd3, B_INCR, gb, gr, tow);
    join
    vectors++;
    if (tor || tow || gb !== 4'd12 || gr !== OKAY) begin
      miscompares++;
      $display("FAIL concurrent_done: rd_to=%0b wr_to=%0b bid=%0d bresp=%0d, want 0 0 12 0", tor, tow, gb, gr);
    end
    for (int i = 0; i < 16; i++) exp_data.push_back(model[512 + i]);
    read_burst(4'd13, 64'h1000, 8'd15, 3'd3, B_INCR, 1'b0, tor, lat);
    for (int i = 0; i < 32; i++) begin
      logic [63:0] ed;
      ed = exp_data.pop_front();
      vectors++;
      if (got_data.size() == 0) begin
        miscompares++; $display("FAIL concurrent_rbeat%0d: missing beat, want data=%h", i, ed);
      end else begin
        logic [63:0] d; logic [1:0] r; logic l; logic [3:0] id;
        d = got_data.pop_front(); r = got_resp.pop_front(); l = got_last.pop_front(); id = got_id.pop_front();
        if (d !== ed || r !== OKAY || l !== (i % 16 == 15) || id !== ((i < 16) ? 4'd11 : 4'd13)) begin
          miscompares++;
          $display("FAIL concurrent_rbeat%0d: data=%h resp=%0d last=%0b id=%0d, want %h 0 %0b %0d",
                   i, d, r, l, id, ed, (i % 16 == 15), (i < 16) ? 11 : 13);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit to, lat;
    issue_ar(4'd14, 64'h400, 8'd7, 3'd3, B_INCR, to);
    rready = 1'b1;
    @(posedge aclk); #1;
    vectors++;
    if (to || rvalid !== 1'b1) begin
      miscompares++; $display("FAIL midrst_beat2: timeout=%0b rvalid=%b, want 0 1", to, rvalid);
    end
    rstn = 1'b0;
    #1;
    vectors++;
    if (rvalid !== 1'b0 || arready !== 1'b0) begin
      miscompares++; $display("FAIL midrst_async: rvalid=%b arready=%b, want 0 0", rvalid, arready);
    end
    rready = 1'b0;
    @(negedge aclk); rstn = 1'b1;
    @(posedge aclk); #1;
    vectors++;
    if (arready !== 1'b1) begin
      miscompares++; $display("FAIL midrst_arready: arready=%b, want 1", arready);
    end
    exp_data.push_back(model[130]); exp_data.push_back(model[131]);
    read_burst(4'd15, 64'h410, 8'd1, 3'd3, B_INCR, 1'b0, to, lat);
    for (int i = 0; i < 2; i++) begin
      logic [63:0] ed;
      ed = exp_data.pop_front();
      vectors++;
      if (got_data.size() == 0) begin
        miscompares++; $display("FAIL midrst_rbeat%0d: missing beat, want data=%h", i, ed);
      end else begin
        logic [63:0] d; logic [1:0] r; logic l; logic [3:0] id;
        d = got_data.pop_front(); r = got_resp.pop_front(); l = got_last.pop_front(); id = got_id.pop_front();
        if (d !== ed || r !== OKAY || l !== (i == 1) || id !== 4'd15) begin
          miscompares++;
          $display("FAIL midrst_rbeat%0d: data=%h resp=%0d last=%0b id=%0d, want %h 0 %0b 15", i, d, r, l, id, ed, (i == 1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_narrow();
    test_wrap();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_sram_responder.md
# axi_sram_responder

AXI4 subordinate endpoint backed by a flat on-chip word array, sitting on the narrow-ID master side of the ID-serializing path in the FPGA block design. It accepts one write burst and one read burst at a time, services both independently, echoes the request ID on B/R, and flags illegal requests with SLVERR. It terminates serialized traffic in block-design test fabrics and acts as a scratchpad for bring-up.

## Interface
- AXI_ID_WIDTH, 4, ID width; equals the upstream master-port ID width.
- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 64, data width in bits; power of two, minimum 32.
- MEM_WORDS, 1024, array depth in data words; power of two.
- aclk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- s_axi_aw{id,addr,len,size,burst}  in  ID/ADDR/8/3/2  write address; s_axi_awvalid in 1, s_axi_awready out 1
- s_axi_w{data,strb,last}  in  DATA/DATA/8/1  write data; s_axi_wvalid in 1, s_axi_wready out 1
- s_axi_b{id,resp}  out  ID/2  write response; s_axi_bvalid out 1, s_axi_bready in 1
- s_axi_ar{id,addr,len,size,burst}  in  ID/ADDR/8/3/2  read address; s_axi_arvalid in 1, s_axi_arready out 1
- s_axi_r{data,resp,last,id}  out  DATA/2/1/ID  read data; s_axi_rvalid out 1, s_axi_rready in 1
- Lock, cache, prot, qos, region, user and atop are not ported. Atomics are filtered upstream.

## Operation
- OFF = log2(DATA/8). Word index = addr[log2(MEM_WORDS)+OFF-1:OFF]. Memory span = MEM_WORDS*DATA/8 bytes from address 0.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On handshake, latch id, addr, len, size and burst, and compute err.
  - W_DATA: wready=1. Each beat writes the byte lanes selected by wstrb at the current word, unless err is set. The address then advances.
  - The beat with wlast moves the FSM to W_RESP. A beat count of len+1 also moves it to W_RESP, and wlast mismatch is ignored.
  - W_RESP: bvalid=1, bid=latched id, bresp=SLVERR(2'b10) if err else OKAY. On bready the FSM returns to W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On handshake, latch the request and load rdata with mem[first word], or 0 if err.
  - R_DATA: rvalid=1, rid=latched id, rresp as for writes, rlast=(beat==len). On each rready handshake, rdata loads the next word in the same cycle. The handshake on the last beat returns the FSM to R_IDLE.
- err is set for any of:
  - burst==2'b11
  - size>OFF
  - any beat address >= span; checked on the first and last beat addresses
  - WRAP with len not in {1,3,7,15}
- Errored bursts still consume every W beat and produce len+1 R beats.
- Address advance, by burst type:
  - FIXED: constant.
  - INCR: (addr & ~((1<<size)-1)) + (1<<size).
  - WRAP: increment within the aligned window of (len+1)<<size bytes, wrapping to the window base.
- Narrow transfers use the master's strobes and the byte lanes as given. rdata always returns the full word.
- 4 KiB boundary crossing is not checked.
- A read and a write to the same word in the same cycle: the read returns the old data.

## Timing
- Reset values: all ready/valid outputs 0; bid, rid, bresp, rresp, rdata, rlast 0; both FSMs in IDLE.
- awready and arready are registered. They rise in the first cycle after rstn deasserts.
- Memory contents are not reset.
- AR handshake at cycle t gives rvalid at t+1. With rready held high, throughput is one beat per cycle.
- AW handshake at t gives wready at t+1. The wlast handshake at t gives bvalid at t+1.
- valid is held with stable payload until its handshake completes.
- Read and write paths never stall each other.
- Reset asserted mid-burst: both FSMs return to IDLE immediately and the partial burst is dropped.

## Configuration
- AXI_SRAM_RESPONDER_WRAP_EN defined: WRAP bursts are supported as above.
- Undefined: any burst==2'b10 sets err (SLVERR), and the wrap-address logic is not synthesized.

## Structure
- Shared package axi_sram_responder_pkg holds:
  - the burst encodings (FIXED/INCR/WRAP)
  - the resp constants (OKAY/SLVERR)
  - the write and read FSM state enums
- Sub-module axi_sram_burst_addr: combinational next-address and err computation from addr, len, size and burst. It is instantiated once for the write path and once for the read path.

## Test plan
- INCR write of 4 beats, id=3, addr 0x40, size 3, data 1..4, full strobes, then INCR read of the same span with id=5 -> bid=3 OKAY; rdata 1,2,3,4, rid=5, rlast only on beat 4, rvalid one cycle after the AR handshake.
- Narrow write with size 0 at addr 0x101, wdata 0xAA in lane 1, wstrb 0x02; then 64-bit read of 0x100 -> only byte 1 equals 0xAA, other bytes unchanged.
- WRAP read, len=3, size 3, addr 0x18 after preloading 0x00..0x18 -> beat addresses 0x18, 0x00, 0x08, 0x10. With the macro undefined -> 4 beats of rdata 0 with SLVERR.
- Write to addr MEM_WORDS*8 with len=1 -> both W beats accepted, memory unchanged, bresp=SLVERR. Read at the same address -> 2 beats of rdata 0 with SLVERR.
- Concurrent 16-beat read and 16-beat write to disjoint regions, with rready toggling every other cycle -> both complete, and data is correct for every beat.
- rstn asserted during beat 2 of an 8-beat read -> rvalid=0 asynchronously. After release, arready=1 within one cycle and a new read completes normally.
